uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ byte-producing requesters on the Tang Nano 9k fabric (27 MHz clk).
- Round-robin arbiter accepts one byte per grant over a valid/ready handshake.
- Serializes each accepted byte as 8N1: start 0, 8 data bits LSB first, stop 1.
- Replaces per-requester fixed-pattern transmitters so several sources can report over the single USB-UART pin.

Parameters:
- CLK_FREQ, 27000000, clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bps.
- NUM_REQ, 4, number of requesters; legal range 1..8.
- BIT_CYCLES, CLK_FREQ/BAUD_RATE (integer truncation), clk cycles per bit (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  byte i at bits [8i+7:8i]; held stable while valid and not ready.
- req_ready  output  NUM_REQ  one-hot accept strobe; high only in the handshake cycle.
- tx  output  1  UART line, idle high.
- busy  output  1  high from the cycle after a handshake until the frame returns to IDLE.
- grant_id  output  max(1,clog2(NUM_REQ))  index of the last-granted requester.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, rr pointer=0, FSM=IDLE, bit/baud counters=0.
- Reset applies mid-frame: tx is 1 on the next edge and the partial frame is abandoned, not resumed.
- FSM states: IDLE, START, DATA, STOP (TAG_START/TAG_DATA/TAG_STOP only with the optional feature).
- IDLE arbitration is combinational. g = the first i with req_valid[i]=1, searching pointer, pointer+1, …, wrapping modulo NUM_REQ.
- req_ready[g]=1 in that same IDLE cycle. The byte is captured and the handshake completes.
- On the handshake edge: pointer <= (g+1) mod NUM_REQ, grant_id <= g, FSM -> START.
- req_ready is 0 in all non-IDLE states. req_valid changes there are ignored, and valid may drop without penalty.
- START: tx=0 for BIT_CYCLES cycles. tx falls exactly 1 cycle after the handshake edge.
- DATA: tx=data[k] for k=0..7, each held BIT_CYCLES cycles.
- STOP: tx=1 for BIT_CYCLES cycles, then IDLE.
- Frame = 10*BIT_CYCLES cycles. At least one IDLE cycle separates frames.
- Minimum handshake-to-handshake spacing = 10*BIT_CYCLES+1 cycles.
- Baud counter counts 0..BIT_CYCLES-1 and wraps. The bit index advances on the wrap.
- Counters are sized with clog2 so no overflow occurs at the 27 MHz / 9600 default (BIT_CYCLES=2812).
- All requesters idle: stay in IDLE with tx=1; the pointer does not move.
- NUM_REQ=1: the arbiter degenerates to pass-through and the pointer stays 0.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined: each grant sends two back-to-back frames, with no idle gap between them.
  - First frame: tag byte 8'h30+g (ASCII '0'..'7').
  - Second frame: the data byte.
  - busy covers both frames; spacing becomes 20*BIT_CYCLES+1.
- Undefined: single data frame only; tag states and the tag mux are absent.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - FSM state enum;
  - FRAME_BITS=10;
  - TAG_BASE=8'h30;
  - MAX_REQ=8.
- Sub-module uart_tx_serializer:
  - takes the byte, a load strobe and BIT_CYCLES;
  - returns tx and done;
  - owns the baud counter and bit index.
- The arbiter top owns the round-robin pointer, handshake and tag sequencing.

Test Plan:
All benches use CLK_FREQ=160, BAUD_RATE=10 (BIT_CYCLES=16) and NUM_REQ=4.
- Single byte: req_valid=4'b0010, data1=8'hA5.
  - req_ready=4'b0010 for exactly 1 cycle; tx low 1 cycle later for 16 cycles.
  - Data bits 1,0,1,0,0,1,0,1 follow at 16 cycles each, then stop high; grant_id=1.
- Round robin: all four valid and held, with data 8'h10..8'h13.
  - Grant order 0,1,2,3,0; handshakes spaced 161 cycles apart.
- Pointer wrap: after grant 3, only req 2 valid -> req 2 granted; with req 0 and req 3 valid, 0 is granted before 3.
- Reset mid-frame: rst pulsed during DATA bit 4.
  - tx=1 on the next edge, busy=0, pointer=0.
  - The next request from req 0 or req 3 grants 0.
- Idle stability: req_valid=0 for 500 cycles -> tx constant 1, req_ready=0, busy=0.
- UART_TX_ARB_TAG_EN: req 2 sends 8'h41 -> frames 8'h32 then 8'h41 back-to-back, 320 cycles of busy.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and FSM state encoding for the UART transmit arbiter.
package uart_tx_arb_pkg;
  localparam int         FRAME_BITS = 10;
  localparam logic [7:0] TAG_BASE   = 8'h30;
  localparam int         MAX_REQ    = 8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_STOP      = 3'd3;
  localparam state_t ST_TAG_START = 3'd4;
  localparam state_t ST_TAG_DATA  = 3'd5;
  localparam state_t ST_TAG_STOP  = 3'd6;
endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: a load strobe (re)starts a frame; the baud counter and bit index live here.
module uart_tx_serializer
  import uart_tx_arb_pkg::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_bit_end,
  output logic [3:0] o_bit_idx,
  output logic       o_done
);
  localparam int             CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit_idx;
  logic [7:0]    r_data;
  logic          r_active;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = r_active && (r_baud == BAUD_LAST);

  // bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
    end else if (i_load) begin
      r_data    <= i_byte;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_active  <= 1'b1;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        r_tx   <= (r_bit_idx < 4'd8) ? r_data[r_bit_idx[2:0]] : 1'b1;
        if (r_bit_idx == LAST_BIT) begin
          r_active  <= 1'b0;
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
        end
      end else begin
        r_baud <= r_baud + CW'(1);
      end
    end
  end

  assign o_tx      = r_tx;
  assign o_bit_end = w_bit_end;
  assign o_bit_idx = r_bit_idx;
  assign o_done    = w_bit_end && (r_bit_idx == LAST_BIT);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART line among NUM_REQ byte sources.
// Define UART_TX_ARB_TAG_EN to prefix every byte with an ASCII requester tag frame.
//
// state     | meaning
// IDLE      | line idle, arbitrating; handshake happens here
// START     | data frame start bit
// DATA      | data frame bits 0..7
// STOP      | data frame stop bit, then back to IDLE
// TAG_START | tag frame start bit
// TAG_DATA  | tag frame bits 0..7
// TAG_STOP  | tag frame stop bit, then straight into START
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int CLK_FREQ  = 27000000,
  parameter  int BAUD_RATE = 9600,
  parameter  int NUM_REQ   = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  state_t                r_state;
  logic [GW-1:0]         r_ptr;
  logic [GW-1:0]         r_grant;
  logic [2*NUM_REQ-1:0]  w_rot_full;
  logic [NUM_REQ-1:0]    w_rot;
  logic                  w_found;
  logic [GW-1:0]         w_gnt;
  logic [GW-1:0]         w_ptr_nxt;
  logic                  w_hs;
  logic [7:0]            w_req_byte;
  logic                  w_load;
  logic [7:0]            w_load_byte;
  logic                  w_bit_end;
  logic                  w_done;
  logic [3:0]            w_bit_idx;
  int                    v_off;
  int                    v_g;
  int                    v_n;

  // rotate so bit 0 is the pointer position; lowest set bit wins
  always_comb begin
    w_rot_full = {req_valid, req_valid} >> r_ptr;
    w_rot      = w_rot_full[NUM_REQ-1:0];
    w_found    = |w_rot;
    v_off      = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) v_off = j;
    end
    v_g = int'(r_ptr) + v_off;
    if (v_g >= NUM_REQ) v_g = v_g - NUM_REQ;
    v_n = v_g + 1;
    if (v_n >= NUM_REQ) v_n = 0;
    w_gnt     = GW'(v_g);
    w_ptr_nxt = GW'(v_n);
  end

  assign w_hs       = !rst && (r_state == ST_IDLE) && w_found;
  assign req_ready  = w_hs ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_req_byte = req_data[8*w_gnt +: 8];

`ifdef UART_TX_ARB_TAG_EN
  logic [7:0] r_byte;

  assign w_load      = w_hs || ((r_state == ST_TAG_STOP) && w_done);
  assign w_load_byte = w_hs ? (TAG_BASE + 8'(w_gnt)) : r_byte;

  always_ff @(posedge clk) begin
    if (rst)       r_byte <= '0;
    else if (w_hs) r_byte <= w_req_byte;
  end
`else
  assign w_load      = w_hs;
  assign w_load_byte = w_req_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_hs) begin
          r_ptr   <= w_ptr_nxt;
          r_grant <= w_gnt;
`ifdef UART_TX_ARB_TAG_EN
          r_state <= ST_TAG_START;
`else
          r_state <= ST_START;
`endif
        end
        ST_START: if (w_bit_end) r_state <= ST_DATA;
        ST_DATA:  if (w_bit_end && (w_bit_idx == 4'd8)) r_state <= ST_STOP;
        ST_STOP:  if (w_done) r_state <= ST_IDLE;
`ifdef UART_TX_ARB_TAG_EN
        ST_TAG_START: if (w_bit_end) r_state <= ST_TAG_DATA;
        ST_TAG_DATA:  if (w_bit_end && (w_bit_idx == 4'd8)) r_state <= ST_TAG_STOP;
        ST_TAG_STOP:  if (w_done) r_state <= ST_START;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_serializer #(.BIT_CYCLES(BIT_CYCLES)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_byte    (w_load_byte),
    .o_tx      (tx),
    .o_bit_end (w_bit_end),
    .o_bit_idx (w_bit_idx),
    .o_done    (w_done)
  );

  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant;
endmodule
